aud_dsp_speed: RTL and testbench

Parametrised variable-speed playback engine between the SRAM recording buffer and the I2S DAC serializer. It reads one sample per DAC frame from SRAM. Supported modes: normal, fast (skip N-1 samples), slow-hold (repeat each sample N frames) and slow-interpolate (linear ramp between consecutive samples over N frames). It generalises the existing playback DSP in data width, address width and speed range, and adds true interpolation.

---
 rtl/aud_dsp_speed_if.sv | 30 +++
 rtl/aud_dsp_speed.sv | 206 ++++++++++++++++++++
 tb/tb_aud_dsp_speed.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aud_dsp_speed_if.sv
// Playback-engine bus: transport controls, SRAM read port and DAC sample output.
// The master drives the i_* signals, the engine (slave) drives the o_* signals.
interface aud_dsp_speed_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned SPEED_W = 3
);
  logic               i_start;
  logic               i_pause;
  logic               i_stop;
  logic [1:0]         i_mode;
  logic [SPEED_W-1:0] i_speed;
  logic               i_daclrck;
  logic [DATA_W-1:0]  i_sram_data;
  logic [ADDR_W-1:0]  i_stop_addr;
  logic [ADDR_W-1:0]  o_sram_addr;
  logic [DATA_W-1:0]  o_dac_data;
  logic [1:0]         o_state;
  logic               o_fin;

  modport master (
    output i_start, i_pause, i_stop, i_mode, i_speed, i_daclrck, i_sram_data, i_stop_addr,
    input  o_sram_addr, o_dac_data, o_state, o_fin
  );

  modport slave (
    input  i_start, i_pause, i_stop, i_mode, i_speed, i_daclrck, i_sram_data, i_stop_addr,
    output o_sram_addr, o_dac_data, o_state, o_fin
  );
endinterface

// File: rtl/aud_dsp_speed.sv
// Variable-speed playback engine: one SRAM sample per DAC frame with normal, fast,
// slow-hold and slow-interpolate modes. o_dac_data is registered on the tick edge.
module aud_dsp_speed #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned SPEED_W = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  aud_dsp_speed_if.slave  bus
);

  localparam int unsigned NW  = SPEED_W + 1;
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam int unsigned PW  = DATA_W + SPEED_W + 2;

  localparam logic [1:0] ModeNormal = 2'b00;
  localparam logic [1:0] ModeFast   = 2'b01;
  localparam logic [1:0] ModeHold   = 2'b10;
  localparam logic [1:0] ModeInterp = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  dac_q, dac_d;
  logic               fin_q, fin_d;
  logic [SPEED_W-1:0] phase_q, phase_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [1:0]         mode_q, mode_d;
  logic [NW-1:0]      n_q, n_d;
  logic               lrck_q;

  logic               tick;
  logic               eod;
  logic [1:0]         eff_mode;
  logic [NW-1:0]      eff_n;
  logic               last;

  assign tick = lrck_q & ~bus.i_daclrck;
  assign eod  = (addr_q >= bus.i_stop_addr);

  // Mode and speed only change at a sample boundary; mid-ramp changes wait.
  always_comb begin
    eff_mode = mode_q;
    eff_n    = n_q;
    if (phase_q == '0) begin
      eff_mode = bus.i_mode;
      eff_n    = {1'b0, bus.i_speed} + NW'(1);
    end
  end

  assign last = ({1'b0, phase_q} == (eff_n - NW'(1)));

  // Interpolation: prev + (cur - prev) * k / N, truncated toward zero.
  logic signed [PW-1:0] cur_ext, prev_ext, diff, k_ext, n_ext, prod, quot, sum;
  logic [DATA_W-1:0]    interp_out;
  logic                 unused_sum_msb;

  always_comb begin
    cur_ext  = {{(PW-DATA_W){bus.i_sram_data[DATA_W-1]}}, bus.i_sram_data};
    prev_ext = {{(PW-DATA_W){prev_q[DATA_W-1]}}, prev_q};
    k_ext    = {{(PW-SPEED_W){1'b0}}, phase_q};
    n_ext    = {{(PW-NW){1'b0}}, eff_n};
    diff     = cur_ext - prev_ext;
    prod     = diff * k_ext;
    quot     = prod / n_ext;
    sum      = prev_ext + quot;
  end

  assign interp_out     = sum[DATA_W-1:0];
  assign unused_sum_msb = ^sum[PW-1:DATA_W];

  // Per-tick results; the address advance saturates at the stop address.
  logic               adv;
  logic [NW-1:0]      inc;
  logic [SPEED_W-1:0] tick_phase;
  logic [DATA_W-1:0]  tick_out;
  logic [ADDR_W:0]    addr_sum;
  logic [ADDR_W-1:0]  addr_adv;

  always_comb begin
    adv        = 1'b1;
    inc        = NW'(1);
    tick_phase = '0;
    tick_out   = bus.i_sram_data;
    unique case (eff_mode)
      ModeNormal: ;
      ModeFast:   inc = eff_n;
      ModeHold: begin
        if (!last) begin
          adv        = 1'b0;
          tick_phase = phase_q + SPEED_W'(1);
        end
      end
      ModeInterp: begin
        // N = 1 degenerates to normal playback rather than a zero-length ramp.
        if (eff_n != NW'(1)) begin
          tick_out = interp_out;
        end
        if (!last) begin
          adv        = 1'b0;
          tick_phase = phase_q + SPEED_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign addr_sum = {1'b0, addr_q} + AW1'(inc);
  assign addr_adv = (addr_sum >= {1'b0, bus.i_stop_addr}) ? bus.i_stop_addr
                                                          : addr_sum[ADDR_W-1:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dac_d   = dac_q;
    fin_d   = fin_q;
    phase_d = phase_q;
    prev_d  = prev_q;
    mode_d  = mode_q;
    n_d     = n_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          state_d = StPlay;
          addr_d  = '0;
          phase_d = '0;
          prev_d  = '0;
          fin_d   = 1'b0;
          mode_d  = bus.i_mode;
          n_d     = {1'b0, bus.i_speed} + NW'(1);
        end
      end
      StPlay: begin
        if (bus.i_stop || eod) begin
          state_d = StIdle;
          addr_d  = '0;
          dac_d   = '0;
          phase_d = '0;
          prev_d  = '0;
          if (!bus.i_stop) begin
            fin_d = 1'b1;
          end
        end else if (bus.i_pause) begin
          state_d = StPause;
          dac_d   = '0;
        end else if (tick) begin
          mode_d  = eff_mode;
          n_d     = eff_n;
          dac_d   = tick_out;
          phase_d = tick_phase;
          if (adv) begin
            addr_d = addr_adv;
            prev_d = bus.i_sram_data;
          end
        end
      end
      StPause: begin
        if (bus.i_stop) begin
          state_d = StIdle;
          addr_d  = '0;
          phase_d = '0;
          prev_d  = '0;
        end else if (bus.i_start) begin
          state_d = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dac_q   <= '0;
      fin_q   <= 1'b0;
      phase_q <= '0;
      prev_q  <= '0;
      mode_q  <= ModeNormal;
      n_q     <= NW'(1);
      lrck_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dac_q   <= dac_d;
      fin_q   <= fin_d;
      phase_q <= phase_d;
      prev_q  <= prev_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      lrck_q  <= bus.i_daclrck;
    end
  end

  assign bus.o_sram_addr = addr_q;
  assign bus.o_dac_data  = dac_q;
  assign bus.o_state     = state_q;
  assign bus.o_fin       = fin_q;

endmodule

// File: tb/tb_aud_dsp_speed.sv
// Bench for aud_dsp_speed: directed scenarios plus randomised playback runs, all
// compared against a frame-level reference model of the playback rules.
module tb_aud_dsp_speed;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned SPEED_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aud_dsp_speed_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SPEED_W(SPEED_W)) bus ();

  aud_dsp_speed #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SPEED_W(SPEED_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // SRAM model: data follows the address with one cycle of latency.
  logic signed [DATA_W-1:0] mem [64];
  always @(posedge clk) bus.i_sram_data <= mem[bus.o_sram_addr[5:0]];

  int checks = 0;
  int errors = 0;

  // Reference model state (0 idle, 1 play, 2 pause).
  int m_state, m_addr, m_phase, m_prev, m_mode, m_n, m_fin, m_out, stop_a;

  int exp_hold[4]   = '{100, 100, 200, 200};
  int exp_interp[8] = '{0, -100, -200, -300, -400, -300, -200, -100};
  int exp_trunc[2]  = '{0, -3};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_addr = 0; m_phase = 0; m_prev = 0;
    m_mode = 0; m_n = 1; m_fin = 0; m_out = 0;
  endtask

  task automatic m_tick();
    int cur, adv, q;
    if (m_phase == 0) begin
      m_mode = int'(bus.i_mode);
      m_n    = int'(bus.i_speed) + 1;
    end
    cur = int'(mem[m_addr]);
    adv = 0;
    case (m_mode)
      0: begin m_out = cur; adv = 1; end
      1: begin m_out = cur; adv = m_n; end
      2: begin m_out = cur; if (m_phase == m_n - 1) adv = 1; end
      default: begin
        q     = ((cur - m_prev) * m_phase) / m_n;
        m_out = (m_n == 1) ? cur : m_prev + q;
        if (m_phase == m_n - 1) adv = 1;
      end
    endcase
    if (adv > 0) begin
      m_addr  = (m_addr + adv >= stop_a) ? stop_a : m_addr + adv;
      m_prev  = cur;
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic m_settle();
    if (m_state == 1 && m_addr >= stop_a) begin
      m_state = 0; m_addr = 0; m_out = 0; m_fin = 1; m_phase = 0; m_prev = 0;
    end
  endtask

  task automatic setup(input int sa, input int mode, input int speed);
    stop_a          = sa;
    bus.i_stop_addr = ADDR_W'(sa);
    bus.i_mode      = 2'(mode);
    bus.i_speed     = SPEED_W'(speed);
    step(2);
  endtask

  task automatic start_pulse();
    bus.i_start = 1'b1;
    step(1);
    bus.i_start = 1'b0;
    m_state = 1; m_addr = 0; m_phase = 0; m_prev = 0; m_fin = 0;
    m_mode = int'(bus.i_mode); m_n = int'(bus.i_speed) + 1;
    step(1);
  endtask

  task automatic frame(input string tag);
    bus.i_daclrck = 1'b1;
    step(3);
    bus.i_daclrck = 1'b0;
    step(1);
    m_tick();
    chk({tag, ".dac"}, $signed(bus.o_dac_data), m_out);
    chk({tag, ".addr"}, bus.o_sram_addr, m_addr);
    step(3);
    m_settle();
    chk({tag, ".state"}, bus.o_state, m_state);
    chk({tag, ".fin"}, bus.o_fin, m_fin);
    chk({tag, ".addr2"}, bus.o_sram_addr, m_addr);
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_pause = 1'b0; bus.i_stop = 1'b0;
    bus.i_mode = 2'b00; bus.i_speed = '0; bus.i_daclrck = 1'b0;
    bus.i_stop_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    m_reset();
    stop_a = 0;
    step(3);
    chk("reset.state", bus.o_state, 0);
    chk("reset.addr", bus.o_sram_addr, 0);
    chk("reset.dac", $signed(bus.o_dac_data), 0);
    chk("reset.fin", bus.o_fin, 0);
    rst_n = 1'b1;
    step(2);

    // Normal playback to end of data.
    mem[0] = 16'sd100; mem[1] = 16'sd200; mem[2] = 16'sd300; mem[3] = 16'sd400;
    setup(4, 0, 0);
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      frame("normal");
      chk("normal.const", $signed(bus.o_dac_data), (i == 3) ? 0 : 100 * (i + 1));
    end
    chk("normal.fin", bus.o_fin, 1);

    // Fast N=3 with saturation at the stop address.
    for (int i = 0; i < 8; i++) mem[i] = 16'(11 * i);
    setup(8, 1, 2);
    start_pulse();
    chk("fast.fin_cleared", bus.o_fin, 0);
    for (int i = 0; i < 3; i++) frame("fast");
    chk("fast.fin", bus.o_fin, 1);

    // Slow-hold N=2.
    mem[0] = 16'sd100; mem[1] = 16'sd200;
    setup(2, 2, 1);
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      bus.i_daclrck = 1'b1; step(3); bus.i_daclrck = 1'b0; step(1);
      m_tick();
      chk("hold.const", $signed(bus.o_dac_data), exp_hold[i]);
      chk("hold.addr", bus.o_sram_addr, m_addr);
      step(3); m_settle();
    end
    chk("hold.state", bus.o_state, 0);

    // Slow-interp N=4 ramp.
    mem[0] = -16'sd400; mem[1] = 16'sd0;
    setup(2, 3, 3);
    start_pulse();
    for (int i = 0; i < 8; i++) begin
      bus.i_daclrck = 1'b1; step(3); bus.i_daclrck = 1'b0; step(1);
      m_tick();
      chk("interp.const", $signed(bus.o_dac_data), exp_interp[i]);
      chk("interp.model", $signed(bus.o_dac_data), m_out);
      step(3); m_settle();
    end
    chk("interp.fin", bus.o_fin, 1);

    // Signed truncation: diff=-7, k=1, N=2 gives -3.
    mem[0] = -16'sd7;
    setup(1, 3, 1);
    start_pulse();
    for (int i = 0; i < 2; i++) begin
      bus.i_daclrck = 1'b1; step(3); bus.i_daclrck = 1'b0; step(1);
      m_tick();
      chk("trunc.const", $signed(bus.o_dac_data), exp_trunc[i]);
      step(3); m_settle();
    end

    // Pause at addr 5 phase 1, ticks ignored, then resume and stop from pause.
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    setup(20, 2, 1);
    start_pulse();
    for (int i = 0; i < 11; i++) frame("prepause");
    chk("pause.addr_pre", bus.o_sram_addr, 5);
    bus.i_pause = 1'b1;
    step(1);
    m_state = 2; m_out = 0;
    chk("pause.state", bus.o_state, 2);
    chk("pause.dac", $signed(bus.o_dac_data), 0);
    for (int i = 0; i < 12; i++) begin
      bus.i_daclrck = 1'b1; step(4); bus.i_daclrck = 1'b0; step(4);
    end
    chk("pause.held_addr", bus.o_sram_addr, 5);
    chk("pause.held_dac", $signed(bus.o_dac_data), 0);
    chk("pause.held_state", bus.o_state, 2);
    bus.i_pause = 1'b0;
    step(1);
    bus.i_start = 1'b1; step(1); bus.i_start = 1'b0;
    m_state = 1;
    step(1);
    chk("resume.state", bus.o_state, 1);
    frame("resume");
    chk("resume.const", $signed(bus.o_dac_data), int'(mem[5]));
    chk("resume.addr", bus.o_sram_addr, 6);
    bus.i_start = 1'b1; step(2); bus.i_start = 1'b0;
    chk("start_in_play.addr", bus.o_sram_addr, 6);
    chk("start_in_play.state", bus.o_state, 1);
    bus.i_pause = 1'b1; step(1); bus.i_pause = 1'b0; step(1);
    bus.i_stop = 1'b1; step(1); bus.i_stop = 1'b0;
    m_reset();
    chk("pstop.state", bus.o_state, 0);
    chk("pstop.addr", bus.o_sram_addr, 0);
    chk("pstop.fin", bus.o_fin, 0);

    // Stop and pause together in PLAY: stop wins.
    setup(20, 0, 0);
    start_pulse();
    frame("sp");
    bus.i_stop = 1'b1; bus.i_pause = 1'b1; step(1);
    bus.i_stop = 1'b0; bus.i_pause = 1'b0;
    m_state = 0; m_addr = 0; m_out = 0; m_phase = 0; m_prev = 0;
    chk("sp.state", bus.o_state, 0);
    chk("sp.addr", bus.o_sram_addr, 0);
    chk("sp.dac", $signed(bus.o_dac_data), 0);

    // Asynchronous reset mid-ramp.
    mem[0] = 16'sd1000; mem[1] = 16'sd0;
    setup(4, 3, 3);
    start_pulse();
    for (int i = 0; i < 5; i++) frame("preRst");
    chk("preRst.dac", $signed(bus.o_dac_data), 1000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.dac", $signed(bus.o_dac_data), 0);
    chk("arst.addr", bus.o_sram_addr, 0);
    chk("arst.state", bus.o_state, 0);
    chk("arst.fin", bus.o_fin, 0);
    m_reset();
    step(2);
    rst_n = 1'b1;
    step(1);

    // Randomised runs with mode/speed changes between frames.
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      setup(int'($urandom_range(3, 40)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)));
      start_pulse();
      for (int f = 0; f < 150 && m_state == 1; f++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_mode  = 2'($urandom_range(0, 3));
          bus.i_speed = SPEED_W'($urandom_range(0, 7));
        end
        frame("rand");
      end
      if (m_state == 1) begin
        bus.i_stop = 1'b1; step(1); bus.i_stop = 1'b0;
        m_state = 0; m_addr = 0; m_out = 0; m_phase = 0; m_prev = 0;
        chk("rand.stop_state", bus.o_state, 0);
        chk("rand.stop_dac", $signed(bus.o_dac_data), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
